// File: rtl/unpacker.sv
// unpacker: two-entry word buffer that unrolls each packed word into a stream
// of DATA_WIDTH items. Items are served on a one-cycle-latency request/valid
// handshake, from the highest used slot down to slot 0, which is the inverse
// of the packer's shift-in order.
module unpacker #(
    parameter int NUM_DATA   = 32,
    parameter int DATA_WIDTH = 8,
    localparam int NUM_W     = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           LdVal,
    output logic                           LdRdy,
    input  logic [DATA_WIDTH*NUM_DATA-1:0] LdDat,
    input  logic [NUM_W-1:0]               LdNum,
    input  logic                           ReqDat,
    output logic                           ValDat,
    output logic [DATA_WIDTH-1:0]          Dat,
    output logic                           FnhUnpacker,
    output logic                           Empty,
    output logic                           ReqErr
);

    logic [DATA_WIDTH*NUM_DATA-1:0] buf_word [2];
    logic [NUM_W-1:0]               buf_num  [2];
    logic                           head;
    logic [1:0]                     occ;
    logic [NUM_W-1:0]               cnt_send;

    logic                           load;
    logic                           accept;
    logic                           pop;
    logic                           tail;
    logic [DATA_WIDTH-1:0]          head_slots [NUM_DATA];
    logic [DATA_WIDTH-1:0]          item;

    // Handshake decodes come from registered state only; no pop-to-load path.
    assign Empty  = (occ == 2'd0);
    assign LdRdy  = ~rst && (occ != 2'd2);
    assign load   = LdVal && LdRdy;
    assign accept = ReqDat && ~Empty;
    assign pop    = accept && (cnt_send == '0);
    // Tail is the head slot when empty, the other slot when one entry is held.
    assign tail   = head ^ occ[0];

    // Split the head word into its item slots and pick the one CntSend names.
    always_comb begin
        for (int unsigned k = 0; k < NUM_DATA; k++) begin
            head_slots[k] = buf_word[head][k*DATA_WIDTH +: DATA_WIDTH];
        end
        item = head_slots[cnt_send];
    end

    // Word storage; contents are only meaningful while counted in occ.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_word[tail] <= LdDat;
            buf_num[tail]  <= LdNum;
        end
    end

    // Occupancy, head pointer, item counter and the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= 1'b0;
            occ         <= 2'd0;
            cnt_send    <= '0;
            ValDat      <= 1'b0;
            Dat         <= '0;
            FnhUnpacker <= 1'b0;
            ReqErr      <= 1'b0;
        end else begin
            ValDat      <= accept;
            FnhUnpacker <= pop;
            if (accept) begin
                Dat <= item;
            end
            if (ReqDat && Empty) begin
                ReqErr <= 1'b1;
            end
            if (pop) begin
                head <= ~head;
            end
            if (load && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !load) begin
                occ <= occ - 2'd1;
            end
            // A new head reloads the counter: either the waiting entry, or
            // the word arriving at this very edge when it lands behind a pop
            // or into an empty buffer.
            if (pop) begin
                if (occ == 2'd2) begin
                    cnt_send <= buf_num[~head];
                end else if (load) begin
                    cnt_send <= LdNum;
                end else begin
                    cnt_send <= '0;
                end
            end else if (accept) begin
                cnt_send <= cnt_send - 1'b1;
            end else if (load && Empty) begin
                cnt_send <= LdNum;
            end
        end
    end

endmodule
